// File: rtl/mips_pkg.sv
// Shared types and helpers for the MIPS program-counter stage.
package mips_pkg;

  // Control state of the PC unit; HALT and FAULT are absorbing until reset.
  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2,
    FAULT = 2'd3
  } pc_state_e;

  // Syscall encoding that stops the core unless the top overrides it.
  localparam logic [31:0] DEFAULT_HALT_WORD = 32'h0000_000C;

  // Widen a 16-bit word offset to 32 bits, preserving its sign.
  function automatic logic [31:0] sign_extend16(input logic [15:0] value);
    return {{16{value[15]}}, value};
  endfunction

endpackage

// File: rtl/mips_next_pc.sv
// Combinational next-PC selection: jr > j > taken branch > increment.
module mips_next_pc
  import mips_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        branch,
  input  logic        branch_ne,
  input  logic        zero,
  input  logic        jump,
  input  logic        jump_reg,
  input  logic [15:0] imm16,
  input  logic [25:0] target26,
  input  logic [31:0] rs_value,
  output logic [31:0] next_pc,
  output logic [31:0] pc_plus1
);

  logic        w_taken;
  logic [31:0] w_branch_target;
  logic [31:0] w_jump_target;

  assign pc_plus1        = pc + 32'd1;
  assign w_taken         = (branch & zero) | (branch_ne & ~zero);
  assign w_branch_target = pc_plus1 + sign_extend16(imm16);
  assign w_jump_target   = {pc_plus1[31:26], target26};

  // Priority mux over the candidate targets.
  always_comb begin
    next_pc = pc_plus1;
    if (jump_reg) begin
      next_pc = rs_value;
    end else if (jump) begin
      next_pc = w_jump_target;
    end else if (w_taken) begin
      next_pc = w_branch_target;
    end else begin
      next_pc = pc_plus1;
    end
  end

endmodule

// File: rtl/mips_pc_unit.sv
// PC stage: state, PC register, saturating retire counter and range check.
module mips_pc_unit
  import mips_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 257,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = DEFAULT_HALT_WORD
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic [31:0] instruction,
  input  logic        branch,
  input  logic        branch_ne,
  input  logic        zero,
  input  logic        jump,
  input  logic        jump_reg,
  input  logic [15:0] imm16,
  input  logic [25:0] target26,
  input  logic [31:0] rs_value,
  output logic [31:0] PC,
  output logic [31:0] pc_plus1,
  output logic [31:0] instr_count,
  output logic        halted,
  output logic        fault
);

  localparam logic [31:0] DEPTH_W = 32'(MEM_DEPTH);

  pc_state_e   r_state;
  pc_state_e   w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [31:0] r_count;
  logic [31:0] w_count_nxt;
  logic        r_halted;
  logic        w_halted_nxt;
  logic        r_fault;
  logic        w_fault_nxt;
  logic [31:0] w_next_pc;
  logic [31:0] w_pc_plus1;

  mips_next_pc u_next_pc (
    .pc        (r_pc),
    .branch    (branch),
    .branch_ne (branch_ne),
    .zero      (zero),
    .jump      (jump),
    .jump_reg  (jump_reg),
    .imm16     (imm16),
    .target26  (target26),
    .rs_value  (rs_value),
    .next_pc   (w_next_pc),
    .pc_plus1  (w_pc_plus1)
  );

  // Next-state logic: retire on unstalled RUN cycles, halt beats range fault.
  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_count_nxt  = r_count;
    w_halted_nxt = r_halted;
    w_fault_nxt  = r_fault;
    case (r_state)
      BOOT: begin
        w_state_nxt = RUN;
      end
      RUN: begin
        if (!stall) begin
          if (r_count != 32'hFFFF_FFFF) begin
            w_count_nxt = r_count + 32'd1;
          end else begin
            w_count_nxt = r_count;
          end
          if (instruction == HALT_WORD) begin
            w_state_nxt  = HALT;
            w_halted_nxt = 1'b1;
          end else if (w_next_pc >= DEPTH_W) begin
            w_state_nxt = FAULT;
            w_fault_nxt = 1'b1;
          end else begin
            w_pc_nxt = w_next_pc;
          end
        end else begin
          w_state_nxt = r_state;
        end
      end
      HALT: begin
        w_state_nxt = HALT;
      end
      FAULT: begin
        w_state_nxt = FAULT;
      end
      default: begin
        w_state_nxt = FAULT;
        w_fault_nxt = 1'b1;
      end
    endcase
  end

  // State, PC, counter and sticky flags; async reset forces reset values at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= BOOT;
      r_pc     <= RESET_PC;
      r_count  <= 32'd0;
      r_halted <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_count  <= w_count_nxt;
      r_halted <= w_halted_nxt;
      r_fault  <= w_fault_nxt;
    end
  end

  assign PC          = r_pc;
  assign pc_plus1    = w_pc_plus1;
  assign instr_count = r_count;
  assign halted      = r_halted;
  assign fault       = r_fault;

endmodule

// File: tb/tb_mips_pc_unit.sv
// Scoreboard bench for mips_pc_unit: a reference model pushes expected
// PC/count/flags per cycle and the values are popped after each edge.
module tb_mips_pc_unit;

  localparam logic [31:0] HW    = 32'h0000_000C;
  localparam logic [31:0] PLAIN = 32'h2002_0001;
  localparam int unsigned DEPTH = 257;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic [31:0] instruction;
  logic        branch, branch_ne, zero, jump, jump_reg;
  logic [15:0] imm16;
  logic [25:0] target26;
  logic [31:0] rs_value;
  logic [31:0] PC, pc_plus1, instr_count;
  logic        halted, fault;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] cnt;
    logic        halted;
    logic        fault;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // model state: 0 boot, 1 run, 2 halt, 3 fault
  int          m_state;
  logic [31:0] m_pc, m_cnt;
  logic        m_halted, m_fault;

  mips_pc_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .instruction (instruction),
    .branch      (branch),
    .branch_ne   (branch_ne),
    .zero        (zero),
    .jump        (jump),
    .jump_reg    (jump_reg),
    .imm16       (imm16),
    .target26    (target26),
    .rs_value    (rs_value),
    .PC          (PC),
    .pc_plus1    (pc_plus1),
    .instr_count (instr_count),
    .halted      (halted),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic model_reset();
    m_state  = 0;
    m_pc     = 32'd0;
    m_cnt    = 32'd0;
    m_halted = 1'b0;
    m_fault  = 1'b0;
  endtask

  task automatic model_step();
    logic [31:0] p1, np;
    if (m_state == 0) begin
      m_state = 1;
    end else if (m_state == 1 && !stall) begin
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
      if (instruction == HW) begin
        m_state  = 2;
        m_halted = 1'b1;
      end else begin
        p1 = m_pc + 32'd1;
        if (jump_reg)                                      np = rs_value;
        else if (jump)                                     np = {p1[31:26], target26};
        else if ((branch && zero) || (branch_ne && !zero)) np = p1 + {{16{imm16[15]}}, imm16};
        else                                               np = p1;
        if (np >= DEPTH) begin
          m_state = 3;
          m_fault = 1'b1;
        end else begin
          m_pc = np;
        end
      end
    end
  endtask

  task automatic idle_inputs();
    stall = 1'b0; instruction = PLAIN;
    branch = 1'b0; branch_ne = 1'b0; zero = 1'b0;
    jump = 1'b0; jump_reg = 1'b0;
    imm16 = 16'd0; target26 = 26'd0; rs_value = 32'd0;
  endtask

  // Called just after a negedge with inputs set; checks the state after the next posedge.
  task automatic step(input string tag);
    exp_t e;
    model_step();
    e.pc = m_pc; e.cnt = m_cnt; e.halted = m_halted; e.fault = m_fault;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check({tag, ".pc"}, PC, e.pc);
    check({tag, ".pc1"}, pc_plus1, e.pc + 32'd1);
    check({tag, ".cnt"}, instr_count, e.cnt);
    check({tag, ".halt"}, {31'd0, halted}, {31'd0, e.halted});
    check({tag, ".fault"}, {31'd0, fault}, {31'd0, e.fault});
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic do_jr(input logic [31:0] tgt);
    jump_reg = 1'b1; rs_value = tgt;
    step("jr");
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst.pc", PC, 32'd0);
    check("rst.cnt", instr_count, 32'd0);
    check("rst.flags", {30'd0, halted, fault}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    apply_reset();

    // boot then five plain instructions: 0,0,1,2,3,4,5
    step("boot");
    check("boot.hold", PC, 32'd0);
    for (int i = 0; i < 5; i++) step("seq");
    check("seq.pc", PC, 32'd5);
    check("seq.cnt", instr_count, 32'd5);

    // branches from PC=10
    do_jr(32'd10);
    branch = 1'b1; zero = 1'b1; imm16 = 16'hFFFC; step("beq_t");
    check("beq_taken", PC, 32'd7);
    do_jr(32'd10);
    branch = 1'b1; zero = 1'b0; imm16 = 16'hFFFC; step("beq_nt");
    check("beq_not_taken", PC, 32'd11);
    do_jr(32'd10);
    branch_ne = 1'b1; zero = 1'b0; imm16 = 16'hFFFC; step("bne_t");
    check("bne_taken", PC, 32'd7);

    // priority: jr beats j beats branch
    do_jr(32'd3);
    jump_reg = 1'b1; jump = 1'b1; branch = 1'b1; zero = 1'b1;
    rs_value = 32'd40; target26 = 26'd99; imm16 = 16'd5;
    step("prio");
    check("prio_jr", PC, 32'd40);
    jump = 1'b1; branch = 1'b1; zero = 1'b1; target26 = 26'd100; imm16 = 16'd5;
    step("jump");
    check("jump_target", PC, 32'd100);

    // upper edge: last valid word, then increment past the end faults
    do_jr(32'd256);
    check("last_word", PC, 32'd256);
    step("overrun");
    check("overrun_fault", {31'd0, fault}, 32'd1);
    check("overrun_pc", PC, 32'd256);
    jump_reg = 1'b1; rs_value = 32'd5; step("fault_frozen");

    // negative branch wraps below zero -> fault, count once
    @(negedge clk);
    apply_reset();
    step("boot2");
    branch = 1'b1; zero = 1'b1; imm16 = 16'hFFFD; step("wrap");
    check("wrap_fault", {31'd0, fault}, 32'd1);
    check("wrap_pc", PC, 32'd0);
    check("wrap_cnt", instr_count, 32'd1);
    for (int i = 0; i < 3; i++) begin
      jump_reg = 1'b1; rs_value = $urandom_range(0, 200); instruction = HW;
      step("wrap_frozen");
    end

    // halt word at PC=20 under stall, then released
    @(negedge clk);
    apply_reset();
    step("boot3");
    do_jr(32'd20);
    for (int i = 0; i < 2; i++) begin
      stall = 1'b1; instruction = HW; step("halt_stall");
    end
    check("stall_cnt", instr_count, 32'd1);
    check("stall_nohalt", {31'd0, halted}, 32'd0);
    instruction = HW; jump_reg = 1'b1; rs_value = 32'd50; step("halt");
    check("halt_flag", {31'd0, halted}, 32'd1);
    check("halt_pc", PC, 32'd20);
    check("halt_cnt", instr_count, 32'd2);
    for (int i = 0; i < 3; i++) begin
      instruction = PLAIN; jump_reg = 1'b1; rs_value = 32'd7; step("halt_frozen");
    end

    // async reset between edges while halted
    @(posedge clk);
    #2;
    apply_reset();
    step("boot4");
    step("after_reset");
    check("after_reset_pc", PC, 32'd1);

    if (exp_q.size() != 0) check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mips_pc_unit.md
# mips_pc_unit

Program-counter stage of the single-cycle datapath. Holds the word-indexed PC that addresses the instruction memory, computes the next PC each cycle (sequential, branch, jump, jump-register), and counts retired instructions. It halts on a designated halt word and faults when the next PC falls outside instruction memory. Both halt and fault are sticky until reset.

## Interface
Parameters:
- `MEM_DEPTH`, default 257: number of instruction-memory words. Valid PC range is 0..MEM_DEPTH-1.
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `HALT_WORD`, default 32'h0000_000C: instruction encoding that halts the core (syscall).

Ports:
- `clk`  in  1: the single clock. Rising-edge active.
- `rst_n`  in  1: reset. Asynchronous, active-low.
- `stall`  in  1: hold PC, count and state for this cycle.
- `instruction`  in  32: word currently fetched at PC.
- `branch`  in  1: beq-class branch.
- `branch_ne`  in  1: bne-class branch.
- `zero`  in  1: ALU zero flag.
- `jump`  in  1: j-class jump.
- `jump_reg`  in  1: jr-class jump.
- `imm16`  in  16: branch offset, in words.
- `target26`  in  26: jump target, in words.
- `rs_value`  in  32: jr target, in words.
- `PC`  out  32: current PC (word index).
- `pc_plus1`  out  32: PC+1, used for link and for the datapath.
- `instr_count`  out  32: number of retired instructions.
- `halted`  out  1: sticky halt flag.
- `fault`  out  1: sticky out-of-range flag.

## Operation
- States: BOOT, RUN, HALT, FAULT.
- Reset: state=BOOT, PC=RESET_PC, instr_count=0, halted=0, fault=0.
- BOOT: PC is held for one cycle, then the unit moves unconditionally to RUN. Nothing is counted and the instruction is ignored.
- RUN with stall=1: PC, count and state are all held. Halt and fault detection are suppressed.
- RUN with stall=0:
  - The instruction retires and instr_count increments. The count saturates at 32'hFFFF_FFFF.
  - If instruction==HALT_WORD: state goes to HALT, PC is held and halted is set. Halt takes priority over every next-PC condition.
  - Otherwise next_pc is computed. If next_pc >= MEM_DEPTH (unsigned): state goes to FAULT, PC is held and fault is set.
  - Otherwise PC <= next_pc.
- Next-PC priority, highest first: jump_reg, jump, taken branch, increment.
  - Taken branch = (branch & zero) | (branch_ne & ~zero).
  - Increment: pc_plus1 = PC + 1, modulo 2^32.
  - Branch target = pc_plus1 + sign_extend(imm16), modulo 2^32.
  - Jump target = {pc_plus1[31:26], target26}.
  - Jump-register target = rs_value.
- HALT and FAULT are absorbing states. All inputs are ignored and outputs are frozen until rst_n is asserted.
- Reset asserted mid-operation forces the reset values immediately, without waiting for a clock edge.

## Timing
- PC updates on the rising edge of clk. The instruction that is fetched combinationally from PC is consumed in that same cycle.
- First retirement happens at the second rising edge after rst_n deasserts (the first edge is spent in BOOT).
- pc_plus1 is combinational from PC, so it is valid in the same cycle.
- halted and fault assert on the edge that retires the halt instruction or the faulting instruction. instr_count includes that instruction.
- stall takes effect on the same cycle it is sampled and has no added latency.

## Structure
- Package `mips_pkg`:
  - state enum {BOOT, RUN, HALT, FAULT};
  - default HALT_WORD constant;
  - sign_extend16 function.
- Sub-module `mips_next_pc`: purely combinational target computation and priority mux. Outputs next_pc and pc_plus1.
- Top level holds the state register, the PC register, the saturating counter and the range check.

## Test plan
- Reset, then five plain instructions. Expect PC sequence 0,0,1,2,3,4,5; instr_count=5; halted=0; fault=0.
- PC=10, beq with zero=1, imm16=16'hFFFC. Expect PC=7. Repeat with zero=0: expect PC=11. Repeat as bne with zero=0: expect PC=7.
- At PC=3, assert jump, jump_reg and branch together, with rs_value=40. Expect PC=40 (jump_reg wins).
- PC=0, taken branch with imm16=16'hFFFD, giving target 0xFFFF_FFFE. Expect fault=1, PC stays 0, instr_count increments once, and later inputs have no effect.
- HALT_WORD fetched at PC=20 while stall=1 for 2 cycles, then stall=0. Expect PC=20 throughout, instr_count to increment once only after stall drops, halted=1, and PC frozen afterwards.
- Assert rst_n low between clock edges while in HALT. Expect PC=RESET_PC, halted=0 and instr_count=0 immediately, before the next edge.
